// File: rtl/mem_responder_pkg.sv
// Shared types and default constants for the backing-memory responder.
package mem_pkg;

    localparam int MEM_WORDS_DEF   = 4096;
    localparam int BURST_WORDS_DEF = 4;
    localparam int LATENCY_DEF     = 4;
    localparam int REQ_ADDR_W      = 30;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

    typedef logic [31:0] word_t;

    // Bits needed to hold values 0..n, never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the data cache (master) and memory (slave).
interface mem_responder_if #(
    parameter int BURST_WORDS = mem_pkg::BURST_WORDS_DEF
);
    import mem_pkg::*;

    localparam int IDX_W = $clog2(BURST_WORDS);

    logic                  req_valid;
    logic                  req_ready;
    logic [REQ_ADDR_W-1:0] req_addr;
    logic                  req_write;
    word_t                 req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    word_t                 resp_data;
    logic [IDX_W-1:0]      resp_word_idx;
    logic                  resp_last;

    modport master (
        output req_valid, req_addr, req_write, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_word_idx, resp_last
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_word_idx, resp_last
    );

endinterface

// File: rtl/mem_storage_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module mem_storage_array
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, critical-word-first read bursts
// and single-beat write acknowledges after a fixed access latency.
module mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_WORDS   = MEM_WORDS_DEF,
    parameter int BURST_WORDS = BURST_WORDS_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int IDX_W = $clog2(BURST_WORDS);
    localparam int CNT_W = count_width(LATENCY);

    mem_state_t       state;
    mem_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    addr_q;
    logic             write_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] beat_q;
    word_t            data_q;
    logic             last_q;

    logic             accept;
    logic             wait_done;
    logic             beat_fire;
    logic [IDX_W-1:0] next_idx;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    word_t            mem_rdata;

    // Handshake decode
    always_comb begin
        accept    = (state == IDLE) && bus.req_valid;
        wait_done = (state == WAIT) && (cnt == CNT_W'(1));
        beat_fire = (state == RESP) && bus.resp_ready;
        mem_we    = accept && bus.req_write;
    end

    // The storage port serves the write at acceptance, otherwise the next beat's
    // read; the offset wraps within the block so it never carries into the base.
    always_comb begin
        next_idx = (state == WAIT) ? addr_q[IDX_W-1:0] : idx_q + 1'b1;
        if (state == IDLE) begin
            mem_addr = bus.req_addr[AW-1:0];
        end else begin
            mem_addr              = addr_q;
            mem_addr[IDX_W-1:0]   = next_idx;
        end
    end

    mem_storage_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus.req_wdata),
        .rdata (mem_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready && last_q) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, latency counter and registered beat outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.req_addr[AW-1:0];
            write_q <= bus.req_write;
            cnt     <= CNT_W'(LATENCY);
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
            if (wait_done) begin
                idx_q  <= next_idx;
                beat_q <= '0;
                data_q <= write_q ? '0 : mem_rdata;
                last_q <= write_q;
            end
        end else if (beat_fire && !last_q) begin
            idx_q  <= next_idx;
            beat_q <= beat_q + 1'b1;
            data_q <= mem_rdata;
            last_q <= (beat_q == IDX_W'(BURST_WORDS - 2));
        end
    end

    assign bus.resp_data     = data_q;
    assign bus.resp_word_idx = idx_q;
    assign bus.resp_last     = last_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against an array-based reference memory.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int MW  = 4096;
    localparam int BW  = 4;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_responder_if #(.BURST_WORDS(BW)) bus ();

    mem_responder #(
        .MEM_WORDS   (MW),
        .BURST_WORDS (BW),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    word_t model [MW];
    bit    known [MW];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current (idle) cycle; it is accepted at the next edge.
    task automatic issue(input bit w, input logic [29:0] a, input word_t d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        if (w) begin
            model[a % MW] = d;
            known[a % MW] = 1'b1;
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic check_beat(input bit w, input int base, input int idx, input bit last);
        chk("beat_valid", {31'b0, bus.resp_valid}, 32'd1);
        chk("beat_ready_low", {31'b0, bus.req_ready}, 32'd0);
        if (w) chk("wr_ack_data", bus.resp_data, 32'd0);
        else if (known[base + idx]) chk("rd_data", bus.resp_data, model[base + idx]);
        chk("beat_idx", {30'b0, bus.resp_word_idx}, 32'(idx));
        chk("beat_last", {31'b0, bus.resp_last}, {31'b0, last});
    endtask

    // Starting in cycle t+1 after acceptance: latency window, then every beat.
    task automatic finish(input bit w, input logic [29:0] a, input int stall_beat, input int stall_len);
        int off, base, nb, idx;
        off  = int'(a % BW);
        base = int'(a % MW) - off;
        nb   = w ? 1 : BW;
        for (int c = 1; c <= LAT; c++) begin
            chk("wait_valid", {31'b0, bus.resp_valid}, 32'd0);
            chk("wait_ready", {31'b0, bus.req_ready}, 32'd0);
            step();
        end
        for (int k = 0; k < nb; k++) begin
            idx = (off + k) % BW;
            if (k == stall_beat) begin
                bus.resp_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check_beat(w, base, idx, k == nb - 1);
                    step();
                end
            end
            bus.resp_ready = 1'b1;
            check_beat(w, base, idx, k == nb - 1);
            step();
        end
        chk("ready_after", {31'b0, bus.req_ready}, 32'd1);
        chk("valid_after", {31'b0, bus.resp_valid}, 32'd0);
    endtask

    task automatic txn(input bit w, input logic [29:0] a, input word_t d,
                       input int stall_beat, input int stall_len);
        issue(w, a, d);
        finish(w, a, stall_beat, stall_len);
    endtask

    initial begin
        logic [29:0] ra;
        bit          rw;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        rst            = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_idx", {30'b0, bus.resp_word_idx}, 32'd0);
        chk("rst_resp_last", {31'b0, bus.resp_last}, 32'd0);

        // Single-word write acknowledge
        txn(1'b1, 30'h10, 32'hDEADBEEF, -1, 0);

        // Critical-word-first read
        txn(1'b1, 30'h20, 32'h11, -1, 0);
        txn(1'b1, 30'h21, 32'h22, -1, 0);
        txn(1'b1, 30'h22, 32'h33, -1, 0);
        txn(1'b1, 30'h23, 32'h44, -1, 0);
        txn(1'b0, 30'h22, 32'h0, -1, 0);

        // Backpressure on beat 1 for two cycles
        txn(1'b0, 30'h22, 32'h0, 1, 2);

        // Held request is only accepted after the final handshake
        issue(1'b0, 30'h22, 32'h0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 30'h30;
        bus.req_wdata = 32'h5A5A_0030;
        finish(1'b0, 30'h22, -1, 0);
        model[30'h30] = 32'h5A5A_0030;
        known[30'h30] = 1'b1;
        step();
        bus.req_valid = 1'b0;
        finish(1'b1, 30'h30, -1, 0);
        txn(1'b0, 30'h31, 32'h0, -1, 0);

        // Reset during the latency window drops the response
        issue(1'b0, 30'h22, 32'h0);
        chk("rst_mid_c1_valid", {31'b0, bus.resp_valid}, 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_mid_last", {31'b0, bus.resp_last}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("rst_mid_no_beat", {31'b0, bus.resp_valid}, 32'd0);
            step();
        end
        txn(1'b0, 30'h20, 32'h0, -1, 0);

        // Upper address bits alias onto the same storage word
        txn(1'b1, 30'h1000_0005, 32'hCAFEF00D, -1, 0);
        txn(1'b0, 30'h5, 32'h0, -1, 0);

        // Fill a small region, then random traffic with random backpressure
        for (int i = 0; i < 64; i++) begin
            txn(1'b1, 30'(i), $urandom, -1, 0);
        end
        for (int i = 0; i < 60; i++) begin
            ra = 30'(($urandom & 32'h3FFF_F000) | $urandom_range(0, 63));
            rw = ($urandom_range(0, 2) == 0);
            txn(rw, ra, $urandom, $urandom_range(0, BW - 1), $urandom_range(0, 3));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                chk("idle_gap_valid", {31'b0, bus.resp_valid}, 32'd0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
